// File: rtl/mul_border_stream.sv
// Border multiplier: rate-coded bit-stream product of one operand pair per job, ones counted into o_count.
// Build option: define MUL_BORDER_STREAM_SIGNED_EN for two's complement operands and a product sign.
module mul_border_stream #(
  parameter int WIDTH   = 16,
  parameter int LOG_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_data_i,
  input  logic [WIDTH-1:0]   i_data_w,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_bit,
  output logic               o_sign,
  output logic [LOG_LEN:0]   o_count,
  output logic               o_done
);

  localparam int M = WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [LOG_LEN-1:0] IDX_ONE  = 1;
  localparam logic [LOG_LEN-1:0] IDX_LAST = '1;
  localparam logic [LOG_LEN:0]   CNT_ONE  = 1;

  // Handshake: i_start is taken only while idle; o_valid qualifies o_bit for
  // the L run cycles and o_done pulses once in the cycle after the last one.

  logic [1:0]         state_q, state_d;
  logic [M-1:0]       mag_i_q, mag_i_d;
  logic [M-1:0]       mag_w_q, mag_w_d;
  logic [LOG_LEN-1:0] idx_i_q, idx_i_d;
  logic [LOG_LEN-1:0] idx_w_q, idx_w_d;
  logic [LOG_LEN:0]   count_q, count_d;

  logic         start_accept;
  logic         run;
  logic [M-1:0] new_mag_i;
  logic [M-1:0] new_mag_w;
  logic [M-1:0] rand_i;
  logic [M-1:0] rand_w;
  logic         bit_i;
  logic         bit_w;
  logic         bit_out;

  assign start_accept = (state_q == ST_IDLE) && i_start;
  assign run          = (state_q == ST_RUN);

`ifdef MUL_BORDER_STREAM_SIGNED_EN
  logic sign_q, sign_d;
  logic new_sign;

  // The most negative value has no positive twin, so it clamps to the largest magnitude.
  function automatic logic [M-1:0] abs_sat(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    n = -v;
    if (!v[WIDTH-1])
      return v[M-1:0];
    else if (v[M-1:0] == '0)
      return '1;
    else
      return n[M-1:0];
  endfunction

  always_comb begin
    new_mag_i = abs_sat(i_data_i);
    new_mag_w = abs_sat(i_data_w);
    new_sign  = (i_data_i[WIDTH-1] ^ i_data_w[WIDTH-1]) & (|new_mag_i) & (|new_mag_w);
  end

  always_comb begin
    sign_d = sign_q;
    if (start_accept)
      sign_d = new_sign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sign_q <= 1'b0;
    else
      sign_q <= sign_d;
  end

  assign o_sign = sign_q;
`else
  logic unused_msb;

  always_comb begin
    new_mag_i = i_data_i[M-1:0];
    new_mag_w = i_data_w[M-1:0];
  end

  assign unused_msb = i_data_i[WIDTH-1] ^ i_data_w[WIDTH-1];
  assign o_sign     = 1'b0;
`endif

  // Low-discrepancy thresholds: bit-reversed index in the top LOG_LEN bits.
  always_comb begin
    rand_i = '0;
    rand_w = '0;
    for (int k = 0; k < LOG_LEN; k++) begin
      rand_i[M-1-k] = idx_i_q[k];
      rand_w[M-1-k] = idx_w_q[k];
    end
  end

  assign bit_i   = (mag_i_q > rand_i);
  assign bit_w   = (mag_w_q > rand_w);
  assign bit_out = run & bit_i & bit_w;

  always_comb begin
    state_d = state_q;
    mag_i_d = mag_i_q;
    mag_w_d = mag_w_q;
    idx_i_d = idx_i_q;
    idx_w_d = idx_w_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          mag_i_d = new_mag_i;
          mag_w_d = new_mag_w;
          idx_i_d = '0;
          idx_w_d = '0;
          count_d = '0;
        end
      end
      ST_RUN: begin
        idx_i_d = idx_i_q + IDX_ONE;
        // Weight stream advances only on input ones, correlating the two streams.
        if (bit_i)
          idx_w_d = idx_w_q + IDX_ONE;
        if (bit_out)
          count_d = count_q + CNT_ONE;
        if (idx_i_q == IDX_LAST)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_i_q <= '0;
      mag_w_q <= '0;
      idx_i_q <= '0;
      idx_w_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mag_i_q <= mag_i_d;
      mag_w_q <= mag_w_d;
      idx_i_q <= idx_i_d;
      idx_w_q <= idx_w_d;
      count_q <= count_d;
    end
  end

  assign o_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign o_valid = run;
  assign o_bit   = bit_out;
  assign o_count = count_q;
  assign o_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_border_stream.sv
// Directed bench for mul_border_stream (WIDTH=16, LOG_LEN=8); expectations follow the build's signedness.
module tb_mul_border_stream;

  localparam int WIDTH   = 16;
  localparam int LOG_LEN = 8;
  localparam int L       = 256;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic [WIDTH-1:0]   i_data_i;
  logic [WIDTH-1:0]   i_data_w;
  logic               o_busy;
  logic               o_valid;
  logic               o_bit;
  logic               o_sign;
  logic [LOG_LEN:0]   o_count;
  logic               o_done;

  int total = 0;
  int bad   = 0;

  int          r_first_valid;
  int          r_n_valid;
  int          r_ones;
  int          r_done_cyc;
  int          r_stray_bit;
  logic [8:0]  r_cnt;
  logic        r_sign;
  logic        r_busy_done;
  logic [8:0]  r_cnt_after;
  logic        r_busy_after;

  mul_border_stream #(.WIDTH(WIDTH), .LOG_LEN(LOG_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_data_i (i_data_i),
    .i_data_w (i_data_w),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_bit    (o_bit),
    .o_sign   (o_sign),
    .o_count  (o_count),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  // Launch one job and observe it cycle by cycle (cycle 1 = first cycle after the start edge).
  // poke_cyc > 0 re-pulses i_start with new operands in that cycle.
  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke_cyc);
    @(negedge clk);
    i_start  = 1'b1;
    i_data_i = a;
    i_data_w = b;
    @(negedge clk);
    i_start = 1'b0;
    r_first_valid = -1;
    r_n_valid     = 0;
    r_ones        = 0;
    r_done_cyc    = -1;
    r_stray_bit   = 0;
    r_cnt         = '0;
    r_sign        = 1'b0;
    r_busy_done   = 1'b0;
    r_cnt_after   = '0;
    r_busy_after  = 1'b1;
    for (int cyc = 1; cyc <= L + 10; cyc++) begin
      if (o_valid) begin
        if (r_first_valid < 0) r_first_valid = cyc;
        r_n_valid++;
        if (o_bit) r_ones++;
      end else if (o_bit) begin
        r_stray_bit++;
      end
      if (o_done && r_done_cyc < 0) begin
        r_done_cyc  = cyc;
        r_cnt       = o_count;
        r_sign      = o_sign;
        r_busy_done = o_busy;
      end
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) begin
        r_cnt_after  = o_count;
        r_busy_after = o_busy;
        break;
      end
      if (cyc == poke_cyc) begin
        i_start  = 1'b1;
        i_data_i = 16'h7FFF;
        i_data_w = 16'h7FFF;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_data_i = '0; i_data_w = '0;
    repeat (3) @(negedge clk);
    total++; if ({o_busy, o_valid, o_bit, o_sign, o_done} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {o_busy, o_valid, o_bit, o_sign, o_done}); end
    total++; if (o_count !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({o_busy, o_valid, o_done, o_count} !== 12'd0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", {o_busy, o_valid, o_done, o_count}); end
  endtask

  task automatic test_quarter();
    run_job(16'h4000, 16'h4000, 0);
    total++; if (r_n_valid !== L) begin bad++; $display("FAIL quarter_valid_len got=%0d exp=%0d", r_n_valid, L); end
    total++; if (r_first_valid !== 1) begin bad++; $display("FAIL quarter_first_valid got=%0d exp=1", r_first_valid); end
    total++; if (r_done_cyc !== L + 1) begin bad++; $display("FAIL quarter_done_cycle got=%0d exp=%0d", r_done_cyc, L + 1); end
    total++; if (r_cnt !== 9'd64) begin bad++; $display("FAIL quarter_count got=%0d exp=64", r_cnt); end
    total++; if (r_ones !== 64) begin bad++; $display("FAIL quarter_stream_ones got=%0d exp=64", r_ones); end
    total++; if (r_sign !== 1'b0) begin bad++; $display("FAIL quarter_sign got=%0d exp=0", r_sign); end
    total++; if (r_busy_done !== 1'b1) begin bad++; $display("FAIL quarter_busy_in_done got=%0d exp=1", r_busy_done); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL quarter_busy_after got=%0d exp=0", r_busy_after); end
    total++; if (r_cnt_after !== 9'd64) begin bad++; $display("FAIL quarter_count_hold got=%0d exp=64", r_cnt_after); end
    total++; if (r_stray_bit !== 0) begin bad++; $display("FAIL quarter_bit_unqualified got=%0d exp=0", r_stray_bit); end
  endtask

  task automatic test_full();
    run_job(16'h7FFF, 16'h7FFF, 0);
    total++; if (r_ones !== L) begin bad++; $display("FAIL full_stream_ones got=%0d exp=%0d", r_ones, L); end
    total++; if (r_cnt !== 9'd256) begin bad++; $display("FAIL full_count got=%0d exp=256", r_cnt); end
    total++; if (r_done_cyc !== L + 1) begin bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", r_done_cyc, L + 1); end
  endtask

  task automatic test_zero();
    run_job(16'h0000, 16'h7FFF, 0);
    total++; if (r_ones !== 0) begin bad++; $display("FAIL zero_stream_ones got=%0d exp=0", r_ones); end
    total++; if (r_cnt !== 9'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", r_cnt); end
    total++; if (r_sign !== 1'b0) begin bad++; $display("FAIL zero_sign got=%0d exp=0", r_sign); end
    total++; if (r_done_cyc !== L + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=%0d", r_done_cyc, L + 1); end
    total++; if (r_n_valid !== L) begin bad++; $display("FAIL zero_valid_len got=%0d exp=%0d", r_n_valid, L); end
  endtask

  task automatic test_signed();
    logic [WIDTH-1:0] ta [5];
    logic [WIDTH-1:0] tw [5];
    int               tc [5];
    logic             ts [5];
    ta[0] = 16'hC000; tw[0] = 16'h4000;
    ta[1] = 16'h8000; tw[1] = 16'h7FFF;
    ta[2] = 16'hFFFF; tw[2] = 16'h7FFF;
    ta[3] = 16'h0000; tw[3] = 16'hC000;
    ta[4] = 16'h4000; tw[4] = 16'hC000;
`ifdef MUL_BORDER_STREAM_SIGNED_EN
    tc[0] = 64;  ts[0] = 1'b1;
    tc[1] = 256; ts[1] = 1'b1;
    tc[2] = 1;   ts[2] = 1'b1;
    tc[3] = 0;   ts[3] = 1'b0;
    tc[4] = 64;  ts[4] = 1'b1;
`else
    tc[0] = 64;  ts[0] = 1'b0;
    tc[1] = 0;   ts[1] = 1'b0;
    tc[2] = 256; ts[2] = 1'b0;
    tc[3] = 0;   ts[3] = 1'b0;
    tc[4] = 64;  ts[4] = 1'b0;
`endif
    for (int t = 0; t < 5; t++) begin
      run_job(ta[t], tw[t], 0);
      total++; if (r_cnt !== tc[t][8:0]) begin bad++; $display("FAIL signed_count[%0d] got=%0d exp=%0d", t, r_cnt, tc[t]); end
      total++; if (r_sign !== ts[t]) begin bad++; $display("FAIL signed_sign[%0d] got=%0d exp=%0d", t, r_sign, ts[t]); end
      total++; if (r_ones !== tc[t]) begin bad++; $display("FAIL signed_stream_ones[%0d] got=%0d exp=%0d", t, r_ones, tc[t]); end
      total++; if (r_done_cyc !== L + 1) begin bad++; $display("FAIL signed_done_cycle[%0d] got=%0d exp=%0d", t, r_done_cyc, L + 1); end
    end
  endtask

  task automatic test_ignore_start();
    run_job(16'h4000, 16'h4000, 10);
    total++; if (r_cnt !== 9'd64) begin bad++; $display("FAIL ignore_count got=%0d exp=64", r_cnt); end
    total++; if (r_n_valid !== L) begin bad++; $display("FAIL ignore_valid_len got=%0d exp=%0d", r_n_valid, L); end
    total++; if (r_done_cyc !== L + 1) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=%0d", r_done_cyc, L + 1); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got=%0d exp=0", r_busy_after); end
  endtask

  task automatic test_abort();
    int seen_done;
    int seen_valid;
    @(negedge clk);
    i_start = 1'b1; i_data_i = 16'h4000; i_data_w = 16'h4000;
    @(negedge clk);
    i_start = 1'b0;
    repeat (99) @(negedge clk);
    // Cycle 100: ones so far at cycles 1,5,...,97.
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL abort_running got=%0d exp=1", o_valid); end
    total++; if (o_count !== 9'd25) begin bad++; $display("FAIL abort_live_count got=%0d exp=25", o_count); end
    rst = 1'b1;
    #1;
    total++; if ({o_busy, o_valid, o_bit, o_sign, o_done, o_count} !== 14'd0) begin bad++; $display("FAIL abort_immediate got=%h exp=0", {o_busy, o_valid, o_bit, o_sign, o_done, o_count}); end
    @(negedge clk);
    total++; if ({o_busy, o_valid, o_done, o_count} !== 12'd0) begin bad++; $display("FAIL abort_next_cycle got=%h exp=0", {o_busy, o_valid, o_done, o_count}); end
    rst = 1'b0;
    seen_done  = 0;
    seen_valid = 0;
    repeat (L + 10) begin
      @(negedge clk);
      if (o_done) seen_done++;
      if (o_valid) seen_valid++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL abort_no_restart got=%0d exp=0", seen_valid); end
  endtask

  task automatic test_back_to_back();
    int         done1;
    int         done2;
    logic       v_l2;
    logic       v_l3;
    logic [8:0] c_l2;
    logic [8:0] c_l3;
    logic [8:0] c_l4;
    logic [8:0] c_done2;
    done1 = -1; done2 = -1;
    v_l2 = 1'b1; v_l3 = 1'b0; c_l2 = '0; c_l3 = '1; c_l4 = '0; c_done2 = '0;
    @(negedge clk);
    i_start = 1'b1; i_data_i = 16'h4000; i_data_w = 16'h4000;
    @(negedge clk);
    for (int cyc = 1; cyc <= 2 * L + 10; cyc++) begin
      if (o_done && done1 < 0) done1 = cyc;
      else if (o_done && done2 < 0) begin done2 = cyc; c_done2 = o_count; end
      if (cyc == L + 2) begin v_l2 = o_valid; c_l2 = o_count; end
      if (cyc == L + 3) begin v_l3 = o_valid; c_l3 = o_count; i_start = 1'b0; end
      if (cyc == L + 4) c_l4 = o_count;
      if (done2 >= 0) break;
      @(negedge clk);
    end
    i_start = 1'b0;
    total++; if (done1 !== L + 1) begin bad++; $display("FAIL b2b_done1_cycle got=%0d exp=%0d", done1, L + 1); end
    total++; if (v_l2 !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap_valid got=%0d exp=0", v_l2); end
    total++; if (c_l2 !== 9'd64) begin bad++; $display("FAIL b2b_count_hold got=%0d exp=64", c_l2); end
    total++; if (v_l3 !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%0d exp=1", v_l3); end
    total++; if (c_l3 !== 9'd0) begin bad++; $display("FAIL b2b_count_cleared got=%0d exp=0", c_l3); end
    total++; if (c_l4 !== 9'd1) begin bad++; $display("FAIL b2b_count_first_inc got=%0d exp=1", c_l4); end
    total++; if (done2 !== 2 * L + 3) begin bad++; $display("FAIL b2b_done2_cycle got=%0d exp=%0d", done2, 2 * L + 3); end
    total++; if (c_done2 !== 9'd64) begin bad++; $display("FAIL b2b_count2 got=%0d exp=64", c_done2); end
  endtask

  initial begin
    test_reset();
    test_quarter();
    test_full();
    test_zero();
    test_signed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
